pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255; max cycles waiting on dmem_ready before the error state.
REQ-002 Parameter DRAIN_CYCLES, default 3; bubble cycles issued after halt_req before the halted state.
REQ-003 Ports: clk  in  1  single clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Inputs, all 1 bit: load_use (ID-stage load-use hazard), branch_taken (EX-stage redirect), dmem_req (MEM-stage access), dmem_ready (memory ack), halt_req, resume.
REQ-005 Enable outputs, all 1 bit: pc_write (PC may update), ifid_write (IF/ID may load), exmem_write (EX/MEM and ID/EX may load).
REQ-006 Bubble outputs, all 1 bit: ifid_flush (zero IF/ID), idex_bubble (zero ID/EX control), memwb_bubble (zero MEM/WB control).
REQ-007 Status outputs: state  out  3  FSM state; halted  out  1; bus_error  out  1.
REQ-008 Counter outputs: stall_cycles  out  32; flush_count  out  32.

Function
REQ-009 FSM SHALL have states RUN, MEM_WAIT, DRAIN, HALTED, ERROR; priority MEM_WAIT > branch flush > load-use > halt.
REQ-010 RUN, no event: pc_write=ifid_write=exmem_write=1; all bubbles 0.
REQ-011 RUN with dmem_req & !dmem_ready: same cycle, all enables 0 and memwb_bubble=1; next state MEM_WAIT, timeout counter cleared.
REQ-012 RUN with dmem_req & dmem_ready: treated as no memory event; single-cycle access, no stall.
REQ-013 RUN, branch_taken (no memory stall): ifid_flush=1, idex_bubble=1, pc_write=1, combinational; flush_count +1.
REQ-014 RUN, load_use (no memory stall, no branch): pc_write=0, ifid_write=0, idex_bubble=1 for that cycle only; stall_cycles +1.
REQ-015 branch_taken with load_use in the same cycle: branch wins; load_use ignored.
REQ-016 MEM_WAIT: all enables 0, memwb_bubble=1; on dmem_ready, outputs are as in REQ-010 that cycle and next state is RUN.
REQ-017 MEM_WAIT: counter increments each cycle; when it reaches MEM_TIMEOUT without dmem_ready, next state ERROR.
REQ-018 ERROR: all enables 0, bus_error=1; held until reset; resume has no effect.
REQ-019 halt_req in RUN with no other event: next state DRAIN; pc_write=0, ifid_write=0.
REQ-020 DRAIN: pc_write=ifid_write=0, idex_bubble=1, exmem_write=1 for DRAIN_CYCLES cycles, then HALTED.
REQ-021 A memory stall during DRAIN SHALL freeze the drain count and behave per REQ-016/017, then return to DRAIN.
REQ-022 HALTED: halted=1, all enables 0; resume pulse goes to RUN next cycle; halt_req held there is ignored.
REQ-023 stall_cycles SHALL count every cycle with pc_write=0 outside HALTED/ERROR; both counters wrap at 2^32.

Reset
REQ-024 rst_n low SHALL immediately set state=RUN, clear counters and bus_error, set halted=0.
REQ-025 Reset mid-MEM_WAIT or mid-DRAIN abandons the operation; no pending stall survives reset.

Configuration
REQ-026 Macro STALL_PERF_CNT_EN defined: stall_cycles and flush_count SHALL operate per REQ-013/014/023.
REQ-027 Macro absent: the counter registers are removed; both ports remain and are driven constant 0.

Structure
REQ-028 Shared package pipe_ctrl_pkg SHALL hold the state enum (3-bit encoding) and the DRAIN_CYCLES/MEM_TIMEOUT defaults.
REQ-029 One sub-module, stall_timer: loadable up-counter with clear, enable and terminal-count flag, used for both MEM_WAIT timeout and the DRAIN count.

Verification
REQ-030 load_use=1 for one cycle in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cycles=1.
REQ-031 dmem_req=1, dmem_ready=0 for 4 cycles then 1 -> 4 frozen cycles, memwb_bubble=1, state MEM_WAIT, then RUN.
REQ-032 branch_taken=1 and load_use=1 together -> ifid_flush=1, pc_write=1, flush_count=1, stall_cycles=0.
REQ-033 MEM_TIMEOUT=8, dmem_ready never asserted -> ERROR after 8 wait cycles, bus_error=1; resume pulse leaves it in ERROR.
REQ-034 halt_req pulse in RUN -> 3 DRAIN cycles with idex_bubble=1, then halted=1; resume -> RUN with pc_write=1 next cycle.
REQ-035 rst_n low during MEM_WAIT -> state=RUN and counters 0 immediately, without a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding, control bundle and default parameters
// shared by the pipeline stall controller and its timer.
package pipe_ctrl_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF  = 255;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned TMR_W            = 16;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HALTED   = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = 6'b000_000;
  localparam ctrl_t CTRL_RUN    = 6'b111_000;
  localparam ctrl_t CTRL_FREEZE = 6'b000_001;
  localparam ctrl_t CTRL_BRANCH = 6'b111_110;
  localparam ctrl_t CTRL_LDUSE  = 6'b001_010;
  localparam ctrl_t CTRL_HALT   = 6'b001_000;
  localparam ctrl_t CTRL_DRAIN  = 6'b001_010;

  function automatic logic counts_stall(state_e s);
    return (s != ST_HALTED) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_timer.sv
// stall_timer: loadable up-counter with clear, enable and a terminal-count
// flag; clear has priority over load, load over count.
module stall_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == limit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall/flush/halt controller for a 5-stage pipe.
// Performance counters are built only when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_error,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [TMR_W-1:0] MEM_LIM = TMR_W'(MEM_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DRN_LIM = TMR_W'(DRAIN_CYCLES);

  state_e state_q, state_d;
  logic   ret_drain_q, ret_drain_d;
  ctrl_t  ctl;

  logic mem_stall;
  logic ev_mem, ev_br, ev_lu, ev_halt;
  logic mem_clr, mem_en, mem_tc;
  logic drn_load, drn_en, drn_tc;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign ev_mem    = mem_stall;
  assign ev_br     = ~mem_stall & branch_taken;
  assign ev_lu     = ~mem_stall & ~branch_taken & load_use;
  assign ev_halt   = ~mem_stall & ~branch_taken & ~load_use & halt_req;

  always_comb begin
    state_d     = state_q;
    ret_drain_d = ret_drain_q;
    ctl         = CTRL_IDLE;
    mem_clr     = 1'b0;
    mem_en      = 1'b0;
    drn_load    = 1'b0;
    drn_en      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        unique case (1'b1)
          ev_mem: begin
            ctl         = CTRL_FREEZE;
            mem_clr     = 1'b1;
            ret_drain_d = 1'b0;
            state_d     = ST_MEM_WAIT;
          end
          ev_br:   ctl = CTRL_BRANCH;
          ev_lu:   ctl = CTRL_LDUSE;
          ev_halt: begin
            ctl      = CTRL_HALT;
            drn_load = 1'b1;
            state_d  = ST_DRAIN;
          end
          default: ctl = CTRL_RUN;
        endcase
      end
      ST_MEM_WAIT: begin
        mem_en = 1'b1;
        if (dmem_ready) begin
          ctl     = CTRL_RUN;
          state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
        end else begin
          ctl = CTRL_FREEZE;
          if (mem_tc) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DRAIN: begin
        // the drain timer holds its count while memory is outstanding
        if (mem_stall) begin
          ctl         = CTRL_FREEZE;
          mem_clr     = 1'b1;
          ret_drain_d = 1'b1;
          state_d     = ST_MEM_WAIT;
        end else begin
          ctl    = CTRL_DRAIN;
          drn_en = 1'b1;
          if (drn_tc) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ret_drain_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
    end
  end

  stall_timer #(.W(TMR_W)) u_mem_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mem_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (mem_en),
    .limit    (MEM_LIM),
    .tc       (mem_tc)
  );

  // drain count starts at 1 so it names the drain cycle in progress
  stall_timer #(.W(TMR_W)) u_drn_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (drn_load),
    .load_val (TMR_W'(1)),
    .en       (drn_en),
    .limit    (DRN_LIM),
    .tc       (drn_tc)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_d, stall_q;
  logic [31:0] flush_d, flush_q;
  logic        stall_inc, flush_inc;

  always_comb begin
    stall_inc = ~ctl.pc_write & counts_stall(state_q);
    flush_inc = (state_q == ST_RUN) & ev_br;
    stall_d   = stall_q + {31'd0, stall_inc};
    flush_d   = flush_q + {31'd0, flush_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

  assign pc_write     = ctl.pc_write;
  assign ifid_write   = ctl.ifid_write;
  assign exmem_write  = ctl.exmem_write;
  assign ifid_flush   = ctl.ifid_flush;
  assign idex_bubble  = ctl.idex_bubble;
  assign memwb_bubble = ctl.memwb_bubble;
  assign state        = state_q;
  assign halted       = (state_q == ST_HALTED);
  assign bus_error    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the stall controller.
module tb_pipe_stall_ctrl;

  localparam int MT = 8;
  localparam int DC = 3;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk, rst_n;
  logic load_use, branch_taken, dmem_req, dmem_ready, halt_req, resume;
  logic pc_write, ifid_write, exmem_write;
  logic ifid_flush, idex_bubble, memwb_bubble;
  logic [2:0] state;
  logic halted, bus_error;
  logic [31:0] stall_cycles, flush_count;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // model: 0 run, 1 mem wait, 2 drain, 3 halted, 4 error
  int m_mode, m_wait, m_drain;
  bit m_back;
  bit [31:0] m_stall, m_flush;

  pipe_stall_ctrl #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use(load_use), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .resume(resume),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .state(state), .halted(halted), .bus_error(bus_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // {pc_write, ifid_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble}
  function automatic bit [5:0] model_ctl(int mode, bit lu, bit bt,
                                         bit rq, bit rdy, bit hr);
    bit ms = rq && !rdy;
    case (mode)
      0: begin
        if (ms) return 6'b000001;
        if (bt) return 6'b111110;
        if (lu) return 6'b001010;
        if (hr) return 6'b001000;
        return 6'b111000;
      end
      1: return rdy ? 6'b111000 : 6'b000001;
      2: return ms ? 6'b000001 : 6'b001010;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic model_step();
    bit [5:0] c;
    bit ms;
    c = model_ctl(m_mode, load_use, branch_taken, dmem_req,
                  dmem_ready, halt_req);
    ms = dmem_req && !dmem_ready;
    if (m_mode <= 2 && !c[5]) m_stall++;
    case (m_mode)
      0: begin
        if (ms) begin
          m_mode = 1; m_wait = 0; m_back = 0;
        end else if (branch_taken) begin
          m_flush++;
        end else if (halt_req && !load_use) begin
          m_mode = 2; m_drain = 0;
        end
      end
      1: begin
        if (dmem_ready) m_mode = m_back ? 2 : 0;
        else begin
          m_wait++;
          if (m_wait == MT) m_mode = 4;
        end
      end
      2: begin
        if (ms) begin
          m_mode = 1; m_wait = 0; m_back = 1;
        end else begin
          m_drain++;
          if (m_drain == DC) m_mode = 3;
        end
      end
      3: if (resume) m_mode = 0;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_wait = 0; m_drain = 0; m_back = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("ctl", 32'({pc_write, ifid_write, exmem_write, ifid_flush,
                      idex_bubble, memwb_bubble}),
          32'(model_ctl(m_mode, load_use, branch_taken, dmem_req,
                        dmem_ready, halt_req)));
      chk("state", 32'(state), 32'(m_mode));
      chk("status", 32'({halted, bus_error}),
          32'({m_mode == 3, m_mode == 4}));
      chk("stall_cycles", stall_cycles, PERF ? m_stall : 32'd0);
      chk("flush_count", flush_count, PERF ? m_flush : 32'd0);
    end
  end

  task automatic drive(bit lu, bit bt, bit rq, bit rdy, bit hr, bit rs);
    load_use = lu; branch_taken = bt; dmem_req = rq;
    dmem_ready = rdy; halt_req = hr; resume = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #7 rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_status", 32'({halted, bus_error}), 32'd0);
    chk("rst_counters", stall_cycles | flush_count, 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    tick();

    // single load-use stall
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_ctl", 32'({pc_write, ifid_write, idex_bubble}), 32'b001);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_stall_cnt", stall_cycles, PERF ? 32'd1 : 32'd0);
    chk("lu_resumed", 32'(pc_write), 32'd1);
    tick();

    // branch beats load-use
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("br_ctl", 32'({pc_write, ifid_flush}), 32'b11);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("br_flush_cnt", flush_count, PERF ? 32'd1 : 32'd0);
    chk("br_stall_cnt", stall_cycles, 32'd0);
    tick();

    // four frozen cycles then memory acknowledges
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mw_frozen", 32'({pc_write, ifid_write, exmem_write,
                            memwb_bubble}), 32'b0001);
      if (i > 0) chk("mw_state", 32'(state), 32'd1);
      tick();
    end
    drive(0, 0, 1, 1, 0, 0);
    @(negedge clk);
    chk("mw_ack", 32'({state, pc_write, memwb_bubble}), 32'b001_1_0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_back_run", 32'(state), 32'd0);
    chk("mw_stall_cnt", stall_cycles, PERF ? 32'd4 : 32'd0);
    tick();

    // memory timeout into error, resume ignored
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    tick();
    n = 0;
    while (state == 3'd1 && n < 50) begin
      tick();
      n++;
    end
    chk("to_wait_cycles", 32'(n), 32'd8);
    chk("to_error", 32'({state, bus_error}), 32'b100_1);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("to_resume_ign", 32'({state, bus_error, pc_write}), 32'b100_1_0);

    // halt, drain, resume
    do_reset();
    drive(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("halt_req_ctl", 32'({pc_write, ifid_write}), 32'b00);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n = 0;
    while (state == 3'd2 && n < 20) begin
      @(negedge clk);
      chk("drain_bubble", 32'({idex_bubble, exmem_write, pc_write}),
          32'b110);
      tick();
      n++;
    end
    chk("drain_cycles", 32'(n), 32'd3);
    chk("halted", 32'({state, halted}), 32'b011_1);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("halt_held", 32'(state), 32'd3);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("resume_run", 32'({state, pc_write}), 32'b000_1);
    tick();

    // asynchronous reset while waiting on memory
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_counters", stall_cycles | flush_count, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_mode == 4 || $urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 10);
        tick();
      end
    end

    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
